// File: rtl/alu_share_arb_pkg.sv
// alu_pkg: shared types and constants for alu_share_arb and alu4_core.
//   Opcode constants, FSM state encoding, flag bit indices and the packed
//   request/response payloads carried between the arbiter and the ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ   = 3'b111;

  // flags vector is {zero, over, cout}
  localparam int unsigned FLAG_COUT = 0;
  localparam int unsigned FLAG_OVER = 1;
  localparam int unsigned FLAG_ZERO = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic [FLAG_W-1:0] flags;
  } rsp_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response channels of the two ALU clients.
//   reqK_valid/ready/op/a/b : operation request from requester K
//   rspK_valid/ready/f/flags: result returned to requester K
//   master = client side, slave = arbiter side.
interface alu_share_arb_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_f;
  logic [FLAG_W-1:0] rsp0_flags;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_f;
  logic [FLAG_W-1:0] rsp1_flags;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_f, rsp0_flags,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_f, rsp1_flags
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_f, rsp0_flags,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_f, rsp1_flags
  );

endinterface

// File: rtl/alu4_core.sv
// alu4_core: purely combinational 4-bit ALU.
//   op   in  opcode
//   a, b in  operands
//   f    out result
//   zero/over/cout out flags (from a-b for SLT/EQ, 0 for logic ops/reserved)
module alu4_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] f,
  output logic              zero,
  output logic              over,
  output logic              cout
);

  logic              sub_mode;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              sum_over;
  logic              sum_zero;

  // Shared adder: everything except ADD computes a + ~b + 1.
  always_comb begin
    sub_mode = (op != OP_ADD);
    b_eff    = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + (DATA_W + 1)'(sub_mode);
    sum_over = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    sum_zero = (sum[DATA_W-1:0] == '0);
  end

  // Result and flag selection.
  always_comb begin
    f    = '0;
    zero = 1'b0;
    over = 1'b0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        f    = sum[DATA_W-1:0];
        zero = sum_zero;
        over = sum_over;
        cout = sum[DATA_W];
      end
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_SLT: begin
        // signed a<b is the sign of a-b corrected by overflow
        f    = DATA_W'(sum[DATA_W-1] ^ sum_over);
        zero = sum_zero;
        over = sum_over;
        cout = sum[DATA_W];
      end
      OP_EQ: begin
        f    = DATA_W'(sum_zero);
        zero = sum_zero;
        over = sum_over;
        cout = sum[DATA_W];
      end
      OP_RSVD: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one alu4_core
// between two requesters (IDLE -> EXEC -> RESP per operation).
//   clk, rst_n  clock, async active-low reset
//   bus         alu_share_arb_if.slave (req/rsp channels of both requesters)
//   grant_cnt0/1 (only with ALU_ARB_STATS_EN) per-requester accept counters
//   PRI_INIT    requester holding priority after reset
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned PRI_INIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]     grant_cnt0,
  output logic [7:0]     grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              pri_q, pri_d;
  logic              owner_q, owner_d;
  logic              grant_c, accept_c, capture_c, resp_c;
  req_t              req_q, req_sel;
  rsp_t              rsp_q, alu_rsp;
  logic [DATA_W-1:0] alu_f;
  logic              alu_zero, alu_over, alu_cout;

  // A lone valid requester wins; on contention the priority holder wins.
  assign grant_c = bus.req1_valid && (!bus.req0_valid || pri_q);

  always_comb begin
    req_sel = grant_c ? {bus.req1_op, bus.req1_a, bus.req1_b}
                      : {bus.req0_op, bus.req0_a, bus.req0_b};
  end

  alu4_core u_alu (
    .op   (req_q.op),
    .a    (req_q.a),
    .b    (req_q.b),
    .f    (alu_f),
    .zero (alu_zero),
    .over (alu_over),
    .cout (alu_cout)
  );

  always_comb begin
    alu_rsp                   = '0;
    alu_rsp.f                 = alu_f;
    alu_rsp.flags[FLAG_ZERO]  = alu_zero;
    alu_rsp.flags[FLAG_OVER]  = alu_over;
    alu_rsp.flags[FLAG_COUT]  = alu_cout;
  end

  // FSM state, priority and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pri_q   <= 1'(PRI_INIT);
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      owner_q <= owner_d;
    end
  end

  // Next state, handshakes, priority rotation on completion.
  always_comb begin
    state_d        = state_q;
    pri_d          = pri_q;
    owner_d        = owner_q;
    accept_c       = 1'b0;
    capture_c      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req0_ready = !grant_c;
        bus.req1_ready = grant_c;
        if (grant_c ? bus.req1_valid : bus.req0_valid) begin
          accept_c = 1'b1;
          owner_d  = grant_c;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture_c = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = ST_IDLE;
          pri_d   = !owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      if (accept_c)  req_q <= req_sel;
      if (capture_c) rsp_q <= alu_rsp;
    end
  end

  // Only the owner sees the result; the other response channel stays zero.
  always_comb begin
    resp_c         = (state_q == ST_RESP);
    bus.rsp0_valid = resp_c && !owner_q;
    bus.rsp1_valid = resp_c && owner_q;
    bus.rsp0_f     = (resp_c && !owner_q) ? rsp_q.f     : '0;
    bus.rsp0_flags = (resp_c && !owner_q) ? rsp_q.flags : '0;
    bus.rsp1_f     = (resp_c && owner_q)  ? rsp_q.f     : '0;
    bus.rsp1_flags = (resp_c && owner_q)  ? rsp_q.flags : '0;
  end

`ifdef ALU_ARB_STATS_EN
  // Accept counters, wrapping at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept_c) begin
      if (owner_d) grant_cnt1 <= grant_cnt1 + 8'(1);
      else         grant_cnt0 <= grant_cnt0 + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed + randomized bench for alu_share_arb with a
// behavioural reference (integer ALU arithmetic, round-robin priority model).
module tb_alu_share_arb;

  localparam int unsigned PRI_INIT = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arb_if bif ();

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0, cnt1;
`endif

  alu_share_arb #(.PRI_INIT(PRI_INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (cnt0),
    .grant_cnt1 (cnt1)
`endif
  );

  logic       d_valid [2];
  logic [2:0] d_op    [2];
  logic [3:0] d_a     [2];
  logic [3:0] d_b     [2];
  logic       d_rrdy  [2];

  assign bif.req0_valid = d_valid[0];
  assign bif.req0_op    = d_op[0];
  assign bif.req0_a     = d_a[0];
  assign bif.req0_b     = d_b[0];
  assign bif.rsp0_ready = d_rrdy[0];
  assign bif.req1_valid = d_valid[1];
  assign bif.req1_op    = d_op[1];
  assign bif.req1_a     = d_a[1];
  assign bif.req1_b     = d_b[1];
  assign bif.rsp1_ready = d_rrdy[1];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int prio;
  bit pend [2];
  int m_cnt [2];

  function automatic logic o_rdy(input int k);
    return (k == 0) ? bif.req0_ready : bif.req1_ready;
  endfunction
  function automatic logic o_rv(input int k);
    return (k == 0) ? bif.rsp0_valid : bif.rsp1_valid;
  endfunction
  function automatic logic [3:0] o_f(input int k);
    return (k == 0) ? bif.rsp0_f : bif.rsp1_f;
  endfunction
  function automatic logic [2:0] o_fl(input int k);
    return (k == 0) ? bif.rsp0_flags : bif.rsp1_flags;
  endfunction

  // Reference ALU from integer arithmetic; returns {f, zero, over, cout}.
  function automatic logic [6:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ua, ub, sa, sb, r;
    logic [3:0] f;
    logic z, o, c;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    f = 4'd0; z = 1'b0; o = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin
        r = sa + sb;
        f = 4'((ua + ub) % 16);
        c = (ua + ub) > 15;
        o = (r > 7) || (r < -8);
        z = (f == 4'd0);
      end
      3'd1, 3'd6, 3'd7: begin
        r = sa - sb;
        c = (ua >= ub);
        o = (r > 7) || (r < -8);
        z = (ua == ub);
        if (op == 3'd1)      f = 4'((ua - ub + 16) % 16);
        else if (op == 3'd6) f = (sa < sb) ? 4'd1 : 4'd0;
        else                 f = (ua == ub) ? 4'd1 : 4'd0;
      end
      3'd3: f = a & b;
      3'd4: f = a | b;
      3'd5: f = a ^ b;
      default: ;
    endcase
    return {f, z, o, c};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    pend[k] = 1'b1;
    d_op[k] = op;
    d_a[k]  = a;
    d_b[k]  = b;
  endtask

  task automatic check_idle_rsp();
    for (int k = 0; k < 2; k++) begin
      check("rsp_valid_idle", 8'(o_rv(k)), 8'd0);
      check("rsp_f_idle",     8'(o_f(k)),  8'd0);
      check("rsp_flags_idle", 8'(o_fl(k)), 8'd0);
    end
  endtask

  // One full operation; called at a negedge while the DUT is idle.
  task automatic run_txn(input int hold);
    int w;
    logic [6:0] exp;
    d_valid[0] = pend[0];
    d_valid[1] = pend[1];
    d_rrdy[0]  = 1'b0;
    d_rrdy[1]  = 1'b0;
    #1;
    w = (pend[0] && pend[1]) ? prio : (pend[1] ? 1 : 0);
    check("grant_ready", 8'(o_rdy(w)), 8'd1);
    check("other_ready", 8'(o_rdy(1 - w)), 8'd0);
    exp = ref_alu(d_op[w], d_a[w], d_b[w]);
    @(posedge clk);
    m_cnt[w] = (m_cnt[w] + 1) % 256;
    @(negedge clk);
    pend[w]    = 1'b0;
    d_valid[w] = 1'b0;
    #1;
    check("exec_rsp_valid0", 8'(o_rv(0)), 8'd0);
    check("exec_rsp_valid1", 8'(o_rv(1)), 8'd0);
    check("exec_ready0", 8'(o_rdy(0)), 8'd0);
    check("exec_ready1", 8'(o_rdy(1)), 8'd0);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      d_rrdy[1 - w] = 1'($urandom);
      #1;
      check("rsp_valid",       8'(o_rv(w)),     8'd1);
      check("rsp_f",           8'(o_f(w)),      8'(exp[6:3]));
      check("rsp_flags",       8'(o_fl(w)),     8'(exp[2:0]));
      check("nonowner_valid",  8'(o_rv(1 - w)), 8'd0);
      check("nonowner_f",      8'(o_f(1 - w)),  8'd0);
      check("nonowner_flags",  8'(o_fl(1 - w)), 8'd0);
      check("resp_ready0",     8'(o_rdy(0)),    8'd0);
      check("resp_ready1",     8'(o_rdy(1)),    8'd0);
    end
    d_rrdy[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_rrdy[0] = 1'b0;
    d_rrdy[1] = 1'b0;
    prio = 1 - w;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; d_valid[k] = 1'b0; d_rrdy[k] = 1'b0; m_cnt[k] = 0;
    end
    prio = int'(PRI_INIT);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      d_op[k] = 3'd0; d_a[k] = 4'd0; d_b[k] = 4'd0;
    end
    apply_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready0", 8'(bif.req0_ready), 8'd1);
    check("reset_ready1", 8'(bif.req1_ready), 8'd0);
    check_idle_rsp();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention with priority 0: sub 3-3 then slt -2 < 1.
    set_req(0, 3'b001, 4'b0011, 4'b0011);
    set_req(1, 3'b110, 4'b1110, 4'b0001);
    run_txn(0);
    run_txn(0);

    // Add overflow 7+1.
    set_req(0, 3'b000, 4'b0111, 4'b0001);
    run_txn(0);

    // Priority now with req1; hold its response 5 cycles while req0 waits.
    set_req(0, 3'b101, 4'b1010, 4'b0110);
    set_req(1, 3'b100, 4'b1001, 4'b0011);
    run_txn(5);
    run_txn(0);

    // Reserved, AND, EQ opcodes.
    set_req(0, 3'b010, 4'b1111, 4'b0001);
    run_txn(0);
    set_req(0, 3'b011, 4'b1100, 4'b1010);
    run_txn(1);
    set_req(0, 3'b111, 4'b0101, 4'b0101);
    run_txn(0);

    // Make req1 the priority holder, then reset during EXEC.
    set_req(0, 3'b000, 4'b0001, 4'b0001);
    run_txn(0);
    d_op[1] = 3'b000; d_a[1] = 4'b1111; d_b[1] = 4'b1111;
    d_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    apply_reset();
    #1;
    check("rst_exec_ready0", 8'(bif.req0_ready), 8'd1);
    check("rst_exec_ready1", 8'(bif.req1_ready), 8'd0);
    check_idle_rsp();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_idle_rsp();
    end
    set_req(0, 3'b001, 4'b1000, 4'b0001);
    set_req(1, 3'b000, 4'b0100, 4'b0100);
    run_txn(0);
    run_txn(2);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && ($urandom_range(0, 1) == 1))
          set_req(k, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      if (!pend[0] && !pend[1])
        set_req(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom),
                4'($urandom));
      run_txn(int'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 2; n++)
      if (pend[0] || pend[1]) run_txn(0);

`ifdef ALU_ARB_STATS_EN
    check("cnt0_random", cnt0, 8'(m_cnt[0]));
    check("cnt1_random", cnt1, 8'(m_cnt[1]));
    apply_reset();
    @(negedge clk);
    check("cnt0_reset", cnt0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 257; n++) begin
      set_req(0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      run_txn(0);
    end
    check("cnt0_wrap", cnt0, 8'd1);
    check("cnt1_wrap", cnt1, 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
